// File: rtl/fetch_decode_alu_if.sv
// Bus between the CPU front half and its instruction memory, register file and data memory.
// No storage in this bundle; signals are driven combinationally except pc, which is a flop.
// No backpressure: every signal is valid in the same cycle.
interface fetch_decode_alu_if;
    logic [31:0] inst;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  wa;
    logic        reg_wen;
    logic [1:0]  reg_src;
    logic [1:0]  mem_cmd;
    logic [31:0] alu_out;
    logic        carry_out;
    logic        is_zero;
    logic        syscall;

    // CPU side: consumes instruction and register data, drives everything else
    modport master (
        input  inst, rd1, rd2,
        output pc, pc_plus4, ra1, ra2, wa, reg_wen, reg_src, mem_cmd,
               alu_out, carry_out, is_zero, syscall
    );

    // Memory / register-file side
    modport slave (
        output inst, rd1, rd2,
        input  pc, pc_plus4, ra1, ra2, wa, reg_wen, reg_src, mem_cmd,
               alu_out, carry_out, is_zero, syscall
    );
endinterface

// File: rtl/fetch_decode_alu.sv
// Single-cycle MIPS-subset front half: PC register, next-PC logic, decode and ALU.
// Latency: decode/ALU combinational; pc advances one instruction per core edge.
// No backpressure: a new instruction is accepted every cycle. Optional macro FDA_SHIFT_EN adds SLL/SRL/SRA.
module fetch_decode_alu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    fetch_decode_alu_if.master bus
);

    typedef enum logic [3:0] {
        ALU_NONE, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_LUI, ALU_SLL, ALU_SRL, ALU_SRA
    } alu_op_e;

    typedef enum logic [1:0] { WA_RD, WA_RT, WA_RA } wa_sel_e;

    typedef struct packed {
        alu_op_e     alu_op;
        logic        b_imm;     // ALU operand b is the immediate instead of rd2
        logic        imm_zext;  // logical immediates are zero-extended
        logic        reg_wen;
        logic [1:0]  reg_src;
        logic [1:0]  mem_cmd;
        wa_sel_e     wa_sel;
        logic        br_eq;
        logic        br_ne;
        logic        jmp;
        logic        jr;
        logic        sys;
    } ctrl_t;

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;
    logic [31:0] imm_ext;
    logic [31:0] opb;
    logic [32:0] sum33, diff33;
    logic [31:0] alu_res;
    logic        carry;
    logic        zero;
    ctrl_t       ctrl;

    assign op    = bus.inst[31:26];
    assign rs    = bus.inst[25:21];
    assign rt    = bus.inst[20:16];
    assign rd    = bus.inst[15:11];
    assign shamt = bus.inst[10:6];
    assign funct = bus.inst[5:0];
    assign imm16 = bus.inst[15:0];

    // Instruction decode into control bundle; anything unrecognised stays a NOP
    always_comb begin
        ctrl          = '0;
        ctrl.alu_op   = ALU_NONE;
        ctrl.wa_sel   = WA_RD;
        case (op)
            6'h00: begin
                case (funct)
                    6'h20, 6'h21: begin ctrl.alu_op = ALU_ADD;  ctrl.reg_wen = 1'b1; end
                    6'h22, 6'h23: begin ctrl.alu_op = ALU_SUB;  ctrl.reg_wen = 1'b1; end
                    6'h24:        begin ctrl.alu_op = ALU_AND;  ctrl.reg_wen = 1'b1; end
                    6'h25:        begin ctrl.alu_op = ALU_OR;   ctrl.reg_wen = 1'b1; end
                    6'h26:        begin ctrl.alu_op = ALU_XOR;  ctrl.reg_wen = 1'b1; end
                    6'h27:        begin ctrl.alu_op = ALU_NOR;  ctrl.reg_wen = 1'b1; end
                    6'h2A:        begin ctrl.alu_op = ALU_SLT;  ctrl.reg_wen = 1'b1; end
                    6'h2B:        begin ctrl.alu_op = ALU_SLTU; ctrl.reg_wen = 1'b1; end
                    6'h08:        ctrl.jr  = 1'b1;
                    6'h0C:        ctrl.sys = 1'b1;
`ifdef FDA_SHIFT_EN
                    // The all-zero word encodes SLL $0,$0,0 but must stay a true NOP
                    6'h00: begin
                        if (bus.inst != 32'h0) begin
                            ctrl.alu_op  = ALU_SLL;
                            ctrl.reg_wen = 1'b1;
                        end
                    end
                    6'h02:        begin ctrl.alu_op = ALU_SRL;  ctrl.reg_wen = 1'b1; end
                    6'h03:        begin ctrl.alu_op = ALU_SRA;  ctrl.reg_wen = 1'b1; end
`endif
                    default: ;
                endcase
            end
            6'h08, 6'h09: begin
                ctrl.alu_op = ALU_ADD; ctrl.b_imm = 1'b1;
                ctrl.reg_wen = 1'b1;   ctrl.wa_sel = WA_RT;
            end
            6'h0A: begin
                ctrl.alu_op = ALU_SLT; ctrl.b_imm = 1'b1;
                ctrl.reg_wen = 1'b1;   ctrl.wa_sel = WA_RT;
            end
            6'h0C, 6'h0D, 6'h0E: begin
                ctrl.alu_op   = (op == 6'h0C) ? ALU_AND : (op == 6'h0D) ? ALU_OR : ALU_XOR;
                ctrl.b_imm    = 1'b1;
                ctrl.imm_zext = 1'b1;
                ctrl.reg_wen  = 1'b1;
                ctrl.wa_sel   = WA_RT;
            end
            6'h0F: begin
                ctrl.alu_op = ALU_LUI; ctrl.reg_wen = 1'b1; ctrl.wa_sel = WA_RT;
            end
            6'h23: begin
                ctrl.alu_op  = ALU_ADD; ctrl.b_imm  = 1'b1;
                ctrl.mem_cmd = 2'd1;    ctrl.reg_src = 2'd1;
                ctrl.reg_wen = 1'b1;    ctrl.wa_sel = WA_RT;
            end
            6'h2B: begin
                ctrl.alu_op  = ALU_ADD; ctrl.b_imm = 1'b1;
                ctrl.mem_cmd = 2'd2;    ctrl.wa_sel = WA_RT;
            end
            6'h04: begin ctrl.alu_op = ALU_SUB; ctrl.br_eq = 1'b1; end
            6'h05: begin ctrl.alu_op = ALU_SUB; ctrl.br_ne = 1'b1; end
            6'h02: ctrl.jmp = 1'b1;
            6'h03: begin
                ctrl.jmp     = 1'b1;  ctrl.reg_wen = 1'b1;
                ctrl.reg_src = 2'd2;  ctrl.wa_sel  = WA_RA;
            end
            default: ;
        endcase
    end

    // ALU: operand selection, arithmetic with carry / not-borrow, logic, compares, shifts
    always_comb begin
        imm_ext = ctrl.imm_zext ? {16'h0, imm16} : {{16{imm16[15]}}, imm16};
        opb     = ctrl.b_imm ? imm_ext : bus.rd2;
        sum33   = {1'b0, bus.rd1} + {1'b0, opb};
        diff33  = {1'b0, bus.rd1} + {1'b0, ~opb} + 33'd1;
        alu_res = 32'h0;
        carry   = 1'b0;
        case (ctrl.alu_op)
            ALU_ADD:  begin alu_res = sum33[31:0];  carry = sum33[32];  end
            ALU_SUB:  begin alu_res = diff33[31:0]; carry = diff33[32]; end
            ALU_AND:  alu_res = bus.rd1 & opb;
            ALU_OR:   alu_res = bus.rd1 | opb;
            ALU_XOR:  alu_res = bus.rd1 ^ opb;
            ALU_NOR:  alu_res = ~(bus.rd1 | opb);
            ALU_SLT:  alu_res = {31'h0, $signed(bus.rd1) < $signed(opb)};
            ALU_SLTU: alu_res = {31'h0, bus.rd1 < opb};
            ALU_LUI:  alu_res = {imm16, 16'h0};
            ALU_SLL:  alu_res = bus.rd2 << shamt;
            ALU_SRL:  alu_res = bus.rd2 >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(bus.rd2) >>> shamt);
            default:  alu_res = 32'h0;
        endcase
        zero = (alu_res == 32'h0);
    end

    // Next-PC selection: sequential, taken branch, absolute jump, or register jump
    always_comb begin
        pc_plus4 = pc_q + 32'd4;
        pc_d     = pc_plus4;
        if ((ctrl.br_eq && zero) || (ctrl.br_ne && !zero))
            pc_d = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
        if (ctrl.jmp)
            pc_d = {pc_plus4[31:28], bus.inst[25:0], 2'b00};
        if (ctrl.jr)
            pc_d = bus.rd1;
    end

    // PC register; reset takes effect immediately, not at the next edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pc_q <= RESET_PC;
        else
            pc_q <= pc_d;
    end

    assign bus.pc        = pc_q;
    assign bus.pc_plus4  = pc_plus4;
    assign bus.ra1       = rs;
    assign bus.ra2       = rt;
    assign bus.wa        = (ctrl.wa_sel == WA_RA) ? 5'd31 :
                           (ctrl.wa_sel == WA_RT) ? rt : rd;
    assign bus.reg_wen   = ctrl.reg_wen;
    assign bus.reg_src   = ctrl.reg_src;
    assign bus.mem_cmd   = ctrl.mem_cmd;
    assign bus.alu_out   = alu_res;
    assign bus.carry_out = carry;
    assign bus.is_zero   = zero;
    assign bus.syscall   = ctrl.sys;

endmodule

// File: tb/tb_fetch_decode_alu.sv
// Directed bench for fetch_decode_alu: one instruction per cycle with hand-computed results.
// Inputs change on the falling edge, outputs are sampled 1 time unit later.
// The DUT never stalls, so no handshake waits are needed.
module tb_fetch_decode_alu;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    fetch_decode_alu_if bus();

    fetch_decode_alu #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] r_inst(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] sh,
                                           input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_inst(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_inst(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.inst = i;
        bus.rd1  = a;
        bus.rd2  = b;
        #1;
    endtask

    initial begin
        bus.inst = 32'h0;
        bus.rd1  = 32'h0;
        bus.rd2  = 32'h0;
        #1 rst = 1'b1;
        #1 chk("reset_pc", bus.pc, 32'h0);

        // ADDU $3,$1,$2 at pc 0, released from reset in the same half cycle
        @(negedge clk);
        rst      = 1'b0;
        bus.inst = r_inst(5'd1, 5'd2, 5'd3, 5'd0, 6'h21);
        bus.rd1  = 32'd7;
        bus.rd2  = 32'd5;
        #1;
        chk("addu_alu",   bus.alu_out,   32'd12);
        chk("addu_wa",    bus.wa,        32'd3);
        chk("addu_wen",   bus.reg_wen,   32'd1);
        chk("addu_src",   bus.reg_src,   32'd0);
        chk("addu_carry", bus.carry_out, 32'd0);
        chk("addu_ra1",   bus.ra1,       32'd1);
        chk("addu_ra2",   bus.ra2,       32'd2);
        chk("addu_pc",    bus.pc,        32'h0);
        chk("addu_pc4",   bus.pc_plus4,  32'h4);

        // pc 0x04: ADD wraps to zero with carry
        step(r_inst(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'hFFFF_FFFF, 32'h1);
        chk("add_alu",   bus.alu_out,   32'h0);
        chk("add_carry", bus.carry_out, 32'd1);
        chk("add_zero",  bus.is_zero,   32'd1);

        // pc 0x08: ADDI with negative immediate
        step(i_inst(6'h08, 5'd1, 5'd4, 16'hFFFF), 32'd5, 32'h0);
        chk("addi_alu", bus.alu_out, 32'd4);
        chk("addi_wa",  bus.wa,      32'd4);
        chk("addi_wen", bus.reg_wen, 32'd1);

        // pc 0x0C: ORI zero-extends
        step(i_inst(6'h0D, 5'd1, 5'd4, 16'h8000), 32'h0, 32'h0);
        chk("ori_alu", bus.alu_out, 32'h0000_8000);

        // pc 0x10: BEQ taken, offset 3 words
        step(i_inst(6'h04, 5'd1, 5'd2, 16'h0003), 32'd9, 32'd9);
        chk("beq_pc",    bus.pc,        32'h10);
        chk("beq_wen",   bus.reg_wen,   32'd0);
        chk("beq_mem",   bus.mem_cmd,   32'd0);
        chk("beq_zero",  bus.is_zero,   32'd1);
        chk("beq_carry", bus.carry_out, 32'd1);

        // pc 0x20: BNE with equal operands falls through
        step(i_inst(6'h05, 5'd1, 5'd2, 16'h0003), 32'd9, 32'd9);
        chk("bne_pc", bus.pc, 32'h20);

        // pc 0x24: SUB with borrow
        step(r_inst(5'd1, 5'd2, 5'd3, 5'd0, 6'h22), 32'd3, 32'd5);
        chk("beq_ne_fallthru_pc", bus.pc, 32'h24);
        chk("sub_alu",   bus.alu_out,   32'hFFFF_FFFE);
        chk("sub_carry", bus.carry_out, 32'd0);

        // pc 0x28: SLT signed, -1 < 1
        step(r_inst(5'd1, 5'd2, 5'd3, 5'd0, 6'h2A), 32'hFFFF_FFFF, 32'd1);
        chk("slt_alu", bus.alu_out, 32'd1);

        // pc 0x2C: SLTU, 0xFFFFFFFF not below 1
        step(r_inst(5'd1, 5'd2, 5'd3, 5'd0, 6'h2B), 32'hFFFF_FFFF, 32'd1);
        chk("sltu_alu",  bus.alu_out, 32'd0);
        chk("sltu_zero", bus.is_zero, 32'd1);

        // pc 0x30: NOR
        step(r_inst(5'd1, 5'd2, 5'd3, 5'd0, 6'h27), 32'h0, 32'h0000_000F);
        chk("nor_alu", bus.alu_out, 32'hFFFF_FFF0);

        // pc 0x34: LUI
        step(i_inst(6'h0F, 5'd0, 5'd5, 16'hABCD), 32'h0, 32'h0);
        chk("lui_alu", bus.alu_out, 32'hABCD_0000);
        chk("lui_wa",  bus.wa,      32'd5);

        // pc 0x38: LW address rd1 + sext(-4)
        step(i_inst(6'h23, 5'd1, 5'd6, 16'hFFFC), 32'h0000_1000, 32'h0);
        chk("lw_alu", bus.alu_out, 32'h0000_0FFC);
        chk("lw_mem", bus.mem_cmd, 32'd1);
        chk("lw_src", bus.reg_src, 32'd1);
        chk("lw_wa",  bus.wa,      32'd6);
        chk("lw_wen", bus.reg_wen, 32'd1);

        // pc 0x3C: SW same address, no write-back
        step(i_inst(6'h2B, 5'd1, 5'd6, 16'hFFFC), 32'h0000_1000, 32'h0);
        chk("sw_alu", bus.alu_out, 32'h0000_0FFC);
        chk("sw_mem", bus.mem_cmd, 32'd2);
        chk("sw_wen", bus.reg_wen, 32'd0);

        // pc 0x40: unknown opcode behaves as NOP
        step(i_inst(6'h3F, 5'd1, 5'd2, 16'h1234), 32'd5, 32'd6);
        chk("unk_pc",  bus.pc,      32'h40);
        chk("unk_wen", bus.reg_wen, 32'd0);
        chk("unk_mem", bus.mem_cmd, 32'd0);
        chk("unk_alu", bus.alu_out, 32'h0);

        // pc 0x44: SYSCALL
        step(r_inst(5'd0, 5'd0, 5'd0, 5'd0, 6'h0C), 32'h0, 32'h0);
        chk("sys_pc",  bus.pc,      32'h44);
        chk("sys_flag", bus.syscall, 32'd1);
        chk("sys_wen", bus.reg_wen, 32'd0);

        // pc 0x48: SLL $5,$2,4 -- only decoded in the shift build
        step(r_inst(5'd0, 5'd2, 5'd5, 5'd4, 6'h00), 32'h0, 32'h1);
`ifdef FDA_SHIFT_EN
        chk("sll_alu", bus.alu_out, 32'h10);
        chk("sll_wen", bus.reg_wen, 32'd1);
`else
        chk("sll_alu", bus.alu_out, 32'h0);
        chk("sll_wen", bus.reg_wen, 32'd0);
`endif

        // pc 0x4C: all-zero word is always a NOP
        step(32'h0, 32'h0, 32'h0);
        chk("nop0_wen", bus.reg_wen, 32'd0);
        chk("nop0_sys", bus.syscall, 32'd0);

        // pc 0x50: J to 0x00400000
        step(j_inst(6'h02, 26'h010_0000), 32'h0, 32'h0);
        chk("j_pc", bus.pc, 32'h50);

        // pc 0x00400000: JAL to 0x00400010
        step(j_inst(6'h03, 26'h010_0004), 32'h0, 32'h0);
        chk("jal_pc",  bus.pc,       32'h0040_0000);
        chk("jal_pc4", bus.pc_plus4, 32'h0040_0004);
        chk("jal_wa",  bus.wa,       32'd31);
        chk("jal_src", bus.reg_src,  32'd2);
        chk("jal_wen", bus.reg_wen,  32'd1);

        // pc 0x00400010: JR to 0x2000
        step(r_inst(5'd5, 5'd0, 5'd0, 5'd0, 6'h08), 32'h0000_2000, 32'h0);
        chk("jr_pc",  bus.pc,      32'h0040_0010);
        chk("jr_wen", bus.reg_wen, 32'd0);

        // pc 0x2000
        step(r_inst(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 32'd1, 32'd1);
        chk("jr_tgt_pc", bus.pc,      32'h2000);
        chk("jr_tgt_alu", bus.alu_out, 32'd2);

        // Asynchronous reset between clock edges
        @(negedge clk);
        #1 chk("pre_rst_pc", bus.pc, 32'h2004);
        #1 rst = 1'b1;
        #1 chk("async_rst_pc", bus.pc, 32'h0);
        @(negedge clk);
        rst      = 1'b0;
        bus.inst = 32'h0;
        #1 chk("rst_hold_pc", bus.pc, 32'h0);
        step(32'h0, 32'h0, 32'h0);
        chk("post_rst_pc", bus.pc, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
